// File: rtl/spectrum_pkg.sv
// rtl/spectrum_pkg.sv - shared spectrum constants, FSM encoding and band packing helpers
package spectrum_pkg;

  localparam int NUM_BANDS   = 8;
  localparam int MAG_W       = 16;
  localparam int BAR_W       = 4;
  localparam int BAR_LEVELS  = 8;
  localparam int DECAY_SHIFT = 3;
  localparam int HOLD_FRAMES = 15;
  localparam int PEAK_FALL   = 256;
  localparam int HOLD_W      = $clog2(HOLD_FRAMES + 1);
  localparam int IDX_W       = $clog2(NUM_BANDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    DONE = 2'd2
  } meter_state_t;

  typedef logic [MAG_W-1:0] mag_t;
  typedef logic [BAR_W-1:0] bar_t;

  // Extract band b from a packed bus where band b sits at [b*MAG_W +: MAG_W]
  function automatic mag_t band_get(input logic [NUM_BANDS*MAG_W-1:0] v, input int b);
    return v[b*MAG_W +: MAG_W];
  endfunction

endpackage

// File: rtl/spectrum_level_meter_if.sv
// rtl/spectrum_level_meter_if.sv - frame input and level output bundle of the level meter
interface spectrum_level_meter_if;
  import spectrum_pkg::*;

  logic                         enable;
  logic                         frame_valid;
  logic [NUM_BANDS*MAG_W-1:0]   band_mag;
  logic [NUM_BANDS*MAG_W-1:0]   level_out;
  logic [NUM_BANDS*MAG_W-1:0]   peak_out;
  logic [NUM_BANDS*BAR_W-1:0]   bar_out;
  logic [NUM_BANDS*BAR_W-1:0]   peak_bar_out;
  logic                         levels_valid;
  logic                         frame_dropped;

  // Upstream side: the FFT/host drives frames and consumes levels
  modport master (
    output enable, frame_valid, band_mag,
    input  level_out, peak_out, bar_out, peak_bar_out, levels_valid, frame_dropped
  );

  // Meter side
  modport slave (
    input  enable, frame_valid, band_mag,
    output level_out, peak_out, bar_out, peak_bar_out, levels_valid, frame_dropped
  );

endinterface

// File: rtl/level_to_bar.sv
// rtl/level_to_bar.sv - combinational MSB-position to bar-height quantiser
module level_to_bar
  import spectrum_pkg::*;
(
  input  mag_t v,
  output bar_t bar
);

  // Bits below the display range never light a bar
  logic unused_low_bits;
  assign unused_low_bits = ^v[MAG_W-BAR_LEVELS-1:0];

  // Ascending scan so the highest set bit in the top BAR_LEVELS bits wins
  always_comb begin
    bar = '0;
    for (int i = MAG_W - BAR_LEVELS; i < MAG_W; i++) begin
      if (v[i]) bar = BAR_W'(i - (MAG_W - BAR_LEVELS) + 1);
    end
  end

endmodule

// File: rtl/spectrum_level_meter.sv
// rtl/spectrum_level_meter.sv - per-band attack/release smoothing, peak hold and bar quantising
module spectrum_level_meter
  import spectrum_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  spectrum_level_meter_if.slave bus
);

  meter_state_t state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic accept, upd_en, commit, drop;

  mag_t              snap    [NUM_BANDS];
  mag_t              level_r [NUM_BANDS];
  mag_t              peak_r  [NUM_BANDS];
  logic [HOLD_W-1:0] hold_r  [NUM_BANDS];
  bar_t              bar_r   [NUM_BANDS];
  bar_t              pbar_r  [NUM_BANDS];

  mag_t new_mag, cur_lvl, cur_pk, diff, dec, lvl_nxt, pk_fall, pk_nxt;
  logic [HOLD_W-1:0] cur_hold, hold_nxt;
  bar_t lvl_bar, pk_bar;

  logic [NUM_BANDS*MAG_W-1:0] level_q, peak_q;
  logic [NUM_BANDS*BAR_W-1:0] bar_q, pbar_q;
  logic levels_valid_q, frame_dropped_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: one snapshot edge, NUM_BANDS band edges, one commit edge
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.frame_valid && bus.enable) state_nxt = PROC;
      PROC:    if (idx == IDX_W'(NUM_BANDS - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM control outputs; a strobe while busy is dropped regardless of enable
  always_comb begin
    accept = (state == IDLE) && bus.frame_valid && bus.enable;
    upd_en = (state == PROC);
    commit = (state == DONE);
    drop   = (state != IDLE) && bus.frame_valid;
  end

  // Band index walks 0..NUM_BANDS-1 during PROC
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         idx <= '0;
    else if (accept) idx <= '0;
    else if (upd_en) idx <= idx + IDX_W'(1);
  end

  // Release/peak arithmetic for the band selected by idx
  always_comb begin
    new_mag  = snap[idx];
    cur_lvl  = level_r[idx];
    cur_pk   = peak_r[idx];
    cur_hold = hold_r[idx];
    diff     = '0;
    dec      = '0;
    if (new_mag >= cur_lvl) begin
      lvl_nxt = new_mag;
    end else begin
      diff = cur_lvl - new_mag;
      dec  = diff >> DECAY_SHIFT;
      if (dec == '0) dec = MAG_W'(1);
      lvl_nxt = cur_lvl - dec;
    end
    pk_fall = (cur_pk > MAG_W'(PEAK_FALL)) ? cur_pk - MAG_W'(PEAK_FALL) : '0;
    if (lvl_nxt >= cur_pk) begin
      pk_nxt   = lvl_nxt;
      hold_nxt = HOLD_W'(HOLD_FRAMES);
    end else if (cur_hold != '0) begin
      pk_nxt   = cur_pk;
      hold_nxt = cur_hold - HOLD_W'(1);
    end else begin
      pk_nxt   = (lvl_nxt > pk_fall) ? lvl_nxt : pk_fall;
      hold_nxt = '0;
    end
  end

  level_to_bar u_level_bar (.v(lvl_nxt), .bar(lvl_bar));
  level_to_bar u_peak_bar  (.v(pk_nxt),  .bar(pk_bar));

  // Snapshot on accept; one band register-file write per PROC clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANDS; b++) begin
        snap[b]    <= '0;
        level_r[b] <= '0;
        peak_r[b]  <= '0;
        hold_r[b]  <= '0;
        bar_r[b]   <= '0;
        pbar_r[b]  <= '0;
      end
    end else begin
      if (accept) begin
        for (int b = 0; b < NUM_BANDS; b++) snap[b] <= band_get(bus.band_mag, b);
      end
      if (upd_en) begin
        level_r[idx] <= lvl_nxt;
        peak_r[idx]  <= pk_nxt;
        hold_r[idx]  <= hold_nxt;
        bar_r[idx]   <= lvl_bar;
        pbar_r[idx]  <= pk_bar;
      end
    end
  end

  // Atomic publish of the finished frame so outputs never show a partial update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q         <= '0;
      peak_q          <= '0;
      bar_q           <= '0;
      pbar_q          <= '0;
      levels_valid_q  <= 1'b0;
      frame_dropped_q <= 1'b0;
    end else begin
      levels_valid_q  <= commit;
      frame_dropped_q <= drop;
      if (commit) begin
        for (int b = 0; b < NUM_BANDS; b++) begin
          level_q[b*MAG_W +: MAG_W] <= level_r[b];
          peak_q[b*MAG_W +: MAG_W]  <= peak_r[b];
          bar_q[b*BAR_W +: BAR_W]   <= bar_r[b];
          pbar_q[b*BAR_W +: BAR_W]  <= pbar_r[b];
        end
      end
    end
  end

  assign bus.level_out     = level_q;
  assign bus.peak_out      = peak_q;
  assign bus.bar_out       = bar_q;
  assign bus.peak_bar_out  = pbar_q;
  assign bus.levels_valid  = levels_valid_q;
  assign bus.frame_dropped = frame_dropped_q;

endmodule

// File: tb/tb_spectrum_level_meter.sv
// tb/tb_spectrum_level_meter.sv - directed self-checking bench for spectrum_level_meter
module tb_spectrum_level_meter;
  import spectrum_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int lv_cnt, dr_cnt;

  spectrum_level_meter_if sif();

  spectrum_level_meter dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_BANDS*MAG_W-1:0] fill(input mag_t v);
    logic [NUM_BANDS*MAG_W-1:0] r;
    for (int b = 0; b < NUM_BANDS; b++) r[b*MAG_W +: MAG_W] = v;
    return r;
  endfunction

  function automatic mag_t lvl_of(input int b);
    return sif.level_out[b*MAG_W +: MAG_W];
  endfunction

  function automatic mag_t pk_of(input int b);
    return sif.peak_out[b*MAG_W +: MAG_W];
  endfunction

  function automatic bar_t bar_of(input int b);
    return sif.bar_out[b*BAR_W +: BAR_W];
  endfunction

  function automatic bar_t pbar_of(input int b);
    return sif.peak_bar_out[b*BAR_W +: BAR_W];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Strobe at E0 and wait (bounded) for levels_valid; returns on the negedge after E9
  task automatic run_frame(input logic [NUM_BANDS*MAG_W-1:0] mags);
    int lat;
    lat = -1;
    sif.band_mag = mags;
    sif.frame_valid = 1'b1;
    @(negedge clk);
    sif.frame_valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (sif.levels_valid && lat < 0) begin
        lat = n;
        break;
      end
    end
    check("latency", 32'(lat), 32'd9);
  endtask

  // Count levels_valid / frame_dropped pulses over a fixed window
  task automatic watch(input int cycles);
    lv_cnt = 0;
    dr_cnt = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (sif.levels_valid) lv_cnt++;
      if (sif.frame_dropped) dr_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sif.enable = 1'b1;
    sif.frame_valid = 1'b0;
    sif.band_mag = '0;
    do_reset();

    // 1: load something, then reset mid-run and expect everything cleared
    run_frame(fill(16'h1234));
    check("pre_rst_level", 32'(lvl_of(0)), 32'h1234);
    rst = 1'b1;
    #1;
    check("rst_level", 32'(|sif.level_out), 32'd0);
    check("rst_peak", 32'(|sif.peak_out), 32'd0);
    check("rst_bar", 32'(|sif.bar_out), 32'd0);
    check("rst_pbar", 32'(|sif.peak_bar_out), 32'd0);
    check("rst_lv", 32'(sif.levels_valid), 32'd0);
    check("rst_drop", 32'(sif.frame_dropped), 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 2: all 0x4000 from reset
    run_frame(fill(16'h4000));
    for (int b = 0; b < NUM_BANDS; b += 7) begin
      check("s2_level", 32'(lvl_of(b)), 32'h4000);
      check("s2_peak", 32'(pk_of(b)), 32'h4000);
      check("s2_bar", 32'(bar_of(b)), 32'd7);
      check("s2_pbar", 32'(pbar_of(b)), 32'd7);
    end

    // 3: one zero frame -> release by 0x4000>>3, peak held
    run_frame(fill(16'h0000));
    check("s3_level", 32'(lvl_of(0)), 32'h3800);
    check("s3_peak", 32'(pk_of(0)), 32'h4000);
    check("s3_bar", 32'(bar_of(0)), 32'd6);
    check("s3_pbar", 32'(pbar_of(0)), 32'd7);

    // 4: zero frames 2..15 keep peak held; frame 16 falls by 256
    for (int f = 2; f <= 15; f++) run_frame(fill(16'h0000));
    check("s4_hold15", 32'(pk_of(3)), 32'h4000);
    run_frame(fill(16'h0000));
    check("s4_fall16", 32'(pk_of(3)), 32'h3F00);
    for (int b = 0; b < NUM_BANDS; b++)
      check("s4_peak_ge_level", 32'(pk_of(b) >= lvl_of(b)), 32'd1);

    // 3b: band independence from a clean state
    do_reset();
    begin
      logic [NUM_BANDS*MAG_W-1:0] m;
      m = '0;
      m[3*MAG_W +: MAG_W] = 16'hFFFF;
      run_frame(m);
    end
    check("ind_level3", 32'(lvl_of(3)), 32'hFFFF);
    check("ind_bar3", 32'(bar_of(3)), 32'd8);
    check("ind_level2", 32'(lvl_of(2)), 32'h0000);
    check("ind_bar0", 32'(bar_of(0)), 32'd0);

    // 5: second strobe 3 clocks after the first is dropped
    do_reset();
    sif.band_mag = fill(16'h1234);
    sif.frame_valid = 1'b1;
    @(negedge clk);
    sif.frame_valid = 1'b0;
    lv_cnt = 0;
    dr_cnt = 0;
    for (int n = 1; n <= 20; n++) begin
      if (n == 3) begin
        sif.band_mag = fill(16'h7777);
        sif.frame_valid = 1'b1;
      end
      @(negedge clk);
      sif.frame_valid = 1'b0;
      if (sif.levels_valid) lv_cnt++;
      if (sif.frame_dropped) dr_cnt++;
    end
    check("s5_drops", 32'(dr_cnt), 32'd1);
    check("s5_valids", 32'(lv_cnt), 32'd1);
    check("s5_level0", 32'(lvl_of(0)), 32'h1234);
    check("s5_level7", 32'(lvl_of(7)), 32'h1234);
    check("s5_bar", 32'(bar_of(5)), 32'd5);

    // 6: reset during PROC aborts the frame silently
    do_reset();
    sif.band_mag = fill(16'h4000);
    sif.frame_valid = 1'b1;
    @(negedge clk);
    sif.frame_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("s6_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    watch(15);
    check("s6_no_valid", 32'(lv_cnt), 32'd0);
    check("s6_level", 32'(|sif.level_out), 32'd0);
    run_frame(fill(16'h0100));
    check("s6_fresh_level", 32'(lvl_of(4)), 32'h0100);
    check("s6_fresh_bar", 32'(bar_of(4)), 32'd1);
    check("s6_fresh_pbar", 32'(pbar_of(4)), 32'd1);

    // enable only gates acceptance: dropping it mid-frame does not abort
    sif.band_mag = fill(16'h0200);
    sif.frame_valid = 1'b1;
    @(negedge clk);
    sif.frame_valid = 1'b0;
    sif.enable = 1'b0;
    watch(15);
    check("en_midframe_valid", 32'(lv_cnt), 32'd1);
    check("en_midframe_level", 32'(lvl_of(1)), 32'h0200);

    // frame with enable low is ignored without a drop pulse
    sif.band_mag = fill(16'h8000);
    sif.frame_valid = 1'b1;
    @(negedge clk);
    sif.frame_valid = 1'b0;
    watch(15);
    check("en_off_valid", 32'(lv_cnt), 32'd0);
    check("en_off_drop", 32'(dr_cnt), 32'd0);
    check("en_off_level", 32'(lvl_of(1)), 32'h0200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
